div_seq: RTL and testbench

- Multi-cycle 16-bit signed divider; the sequential complement to the single-cycle saturating add/sub unit.
- Sits beside that unit in the ALU and is launched by the decode/execute stage with a start pulse.
- Produces a truncated quotient and remainder, with the same saturation convention (0x7FFF / 0x8000) and an overflow flag.
- Restoring algorithm on magnitudes, one quotient bit per clock.

---
 rtl/div_seq_pkg.sv | 21 ++
 rtl/div_step.sv | 30 +++
 rtl/div_seq.sv | 115 +++++++++++
 tb/tb_div_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared ALU definitions: divider FSM states and saturation constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_seq_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Saturation values, common with the saturating add/sub unit
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // Cycles from start sampled to done visible, for the default 16-bit width
  localparam int DIV_W   = 16;
  localparam int DIV_LAT = DIV_W + 2;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift {r,q}, trial subtract.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH:0]   diff;

  // Shift the pair left by one, then keep the trial difference when it does not borrow.
  // r < d <= 2^(WIDTH-1) keeps the shifted remainder inside WIDTH bits.
  always_comb begin
    r_sh  = {r[WIDTH-2:0], q[WIDTH-1]};
    diff  = {1'b0, r_sh} - {1'b0, d};
    r_nxt = r_sh;
    q_nxt = {q[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      r_nxt = diff[WIDTH-1:0];
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed divider: truncated quotient/remainder with saturation, pV and dz flags.
// Latency: fixed WIDTH+2 clocks from start sampled to done, for every operand pair.
// Backpressure: start is only honoured in IDLE; requests while busy or in FIX are dropped.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             pV,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;       // raw dividend, kept for signs and the divide-by-zero remainder
  logic [WIDTH-1:0] dvs;       // raw divisor, kept for signs and corner detection
  logic [WIDTH-1:0] dabs;      // |divisor|
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  // Operand magnitudes; the most negative value maps onto itself, which is the right unsigned magnitude.
  always_comb begin
    dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_abs = divisor[WIDTH-1]  ? -divisor  : divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .r     (r_acc),
    .q     (q_acc),
    .d     (dabs),
    .r_nxt (r_nxt),
    .q_nxt (q_nxt)
  );

  // Control FSM plus datapath; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      dabs  <= '0;
      r_acc <= '0;
      q_acc <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      pV    <= 1'b0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd   <= dividend;
            dvs   <= divisor;
            dabs  <= dvs_abs;
            r_acc <= '0;
            q_acc <= dvd_abs;
            cnt   <= CNT_W'(WIDTH - 1);
            busy  <= 1'b1;
            pV    <= 1'b0;
            dz    <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          r_acc <= r_nxt;
          q_acc <= q_nxt;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          // Zero divisor runs the full iteration count so latency never depends on operands.
          if (dvs == '0) begin
            dz   <= 1'b1;
            quot <= dvd[WIDTH-1] ? SAT_NEG : SAT_POS;
            rem  <= dvd;
          end else if (dvd == SAT_NEG && dvs == '1) begin
            pV   <= 1'b1;
            quot <= SAT_POS;
            rem  <= '0;
          end else begin
            quot <= (dvd[WIDTH-1] ^ dvs[WIDTH-1]) ? -q_acc : q_acc;
            rem  <= dvd[WIDTH-1] ? -r_acc : r_acc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed and randomised checks of div_seq: results, flags, latency, handshake, async reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_seq;
  import div_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        pV;
  logic        dz;

  int errs;
  int nchk;

  div_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .pV       (pV),
    .dz       (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: {quot, rem, pV, dz}; SV integer division truncates toward zero.
  function automatic logic [33:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    int ai;
    int bi;
    logic [15:0] q;
    logic [15:0] r;
    logic pv;
    logic z;
    ai = int'($signed(a));
    bi = int'($signed(b));
    pv = 1'b0;
    z  = 1'b0;
    if (bi == 0) begin
      z = 1'b1;
      q = (ai < 0) ? 16'h8000 : 16'h7FFF;
      r = a;
    end else if (ai == -32768 && bi == -1) begin
      pv = 1'b1;
      q  = 16'h7FFF;
      r  = 16'h0000;
    end else begin
      q = 16'(ai / bi);
      r = 16'(ai % bi);
    end
    return {q, r, pv, z};
  endfunction

  // Launch one division, scramble operands afterwards, wait (bounded) for done.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [33:0] res, output int lat, output int bcnt);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      start    = 1'b0;
      dividend = 16'h5A5A ^ 16'(lat);
      divisor  = 16'(lat);
      lat++;
      if (busy) bcnt++;
    end while (!done && lat < 40);
    res = {quot, rem, pV, dz};
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [33:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[8];
  logic [15:0] corners[6];

  initial begin
    logic [33:0] res;
    int lat;
    int bcnt;
    int ndone;
    int last_done;
    logic [15:0] pa;
    logic [15:0] pb;
    logic [15:0] ra;
    logic [15:0] rb;

    errs = 0;
    nchk = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = 16'h0;
    divisor = 16'h0;

    // Hand-computed vectors: {quot, rem, pV, dz}
    vecs[0] = '{16'h0064, 16'h0007, {16'h000E, 16'h0002, 1'b0, 1'b0}, "pos_pos"};
    vecs[1] = '{16'hFF9C, 16'h0007, {16'hFFF2, 16'hFFFE, 1'b0, 1'b0}, "neg_pos"};
    vecs[2] = '{16'h0064, 16'hFFF9, {16'hFFF2, 16'h0002, 1'b0, 1'b0}, "pos_neg"};
    vecs[3] = '{16'hFF9C, 16'hFFF9, {16'h000E, 16'hFFFE, 1'b0, 1'b0}, "neg_neg"};
    vecs[4] = '{16'h8000, 16'hFFFF, {16'h7FFF, 16'h0000, 1'b1, 1'b0}, "ovf"};
    vecs[5] = '{16'h8000, 16'h0001, {16'h8000, 16'h0000, 1'b0, 1'b0}, "min_by_1"};
    vecs[6] = '{16'h0005, 16'h0000, {16'h7FFF, 16'h0005, 1'b0, 1'b1}, "dz_pos"};
    vecs[7] = '{16'hFFFB, 16'h0000, {16'h8000, 16'hFFFB, 1'b0, 1'b1}, "dz_neg"};

    corners[0] = 16'h7FFF;
    corners[1] = 16'h8000;
    corners[2] = 16'hFFFF;
    corners[3] = 16'h0001;
    corners[4] = 16'h0000;
    corners[5] = 16'h8001;

    // Reset state
    #12;
    chk("reset_outs", {busy, done, quot, rem, pV, dz}, 36'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic op with latency and busy width
    do_op(vecs[0].a, vecs[0].b, res, lat, bcnt);
    chk("basic_res", res, vecs[0].exp);
    chk("basic_lat", lat, DIV_LAT);
    chk("basic_busy", bcnt, 17);

    // Results hold after done
    repeat (3) @(negedge clk);
    chk("hold", {done, quot, rem}, {1'b0, 16'h000E, 16'h0002});

    // Signs, saturation, divide by zero
    for (int i = 1; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, res, lat, bcnt);
      chk(vecs[i].tag, res, vecs[i].exp);
      chk({vecs[i].tag, "_lat"}, lat, DIV_LAT);
    end

    // Start held high with new operands every cycle
    pa = 16'h0;
    pb = 16'h0;
    ndone = 0;
    last_done = 0;
    for (int i = 0; i <= 36; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("hold_start_res", {quot, rem, pV, dz}, ref_div(pa, pb));
        chk("hold_start_gap", i - last_done, DIV_LAT);
        last_done = i;
      end
      if (i == 0 || done) begin
        pa = 16'(200 + i * 3);
        pb = 16'h0007;
      end
      dividend = 16'(200 + i * 3);
      divisor  = 16'h0007;
      start    = (i != 36);
    end
    chk("hold_start_ndone", ndone, 2);

    // Asynchronous reset part way through CALC
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("midop_reset", {busy, done, quot, rem, pV, dz}, 36'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_stray_done", ndone, 0);
    do_op(16'd9, 16'd3, res, lat, bcnt);
    chk("after_reset", res, {16'h0003, 16'h0000, 1'b0, 1'b0});
    chk("after_reset_lat", lat, DIV_LAT);

    // Random pairs against the truncating reference
    for (int i = 0; i < 1500; i++) begin
      ra = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : 16'($urandom);
      rb = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : 16'($urandom);
      if ($urandom_range(3) == 0) rb = 16'($signed(16'($urandom_range(15))) - 16'sd7);
      do_op(ra, rb, res, lat, bcnt);
      chk("rand", {res, 16'(lat)}, {ref_div(ra, rb), 16'(DIV_LAT)});
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
